// File: rtl/bcd_display_scanner_if.sv
// Bus bundle for the four-digit BCD display scanner.
// The host drives LOAD/DIGITS; the scanner drives the display outputs.
interface bcd_display_scanner_if;
   logic        LOAD;
   logic [15:0] DIGITS;
   logic [6:0]  SEG;
   logic [3:0]  AN;
   logic        ERR;
   logic        FRAME;

   modport master (
      output LOAD,
      output DIGITS,
      input  SEG,
      input  AN,
      input  ERR,
      input  FRAME
   );

   modport slave (
      input  LOAD,
      input  DIGITS,
      output SEG,
      output AN,
      output ERR,
      output FRAME
   );
endinterface

// File: rtl/bcd_display_scanner.sv
// Multiplexed four-digit 7-segment scanner with frame-synchronous update,
// leading-zero blanking and a sticky invalid-digit flag.
module bcd_display_scanner #(
   parameter int unsigned SCAN_DIV = 4,
   parameter bit          BLANK_LZ = 1'b1
) (
   input logic                  CLK,
   input logic                  RES,
   bcd_display_scanner_if.slave bus
);

   localparam int unsigned CW =
      (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   pend;
   logic          pend_valid;
   logic [15:0]   disp;
   logic          wrap_q;

   logic          tick;
   logic          frame_edge;
   logic [3:0]    dig;
   logic [3:0]    lz;
   logic [6:0]    seg_nxt;
   logic          bad;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000001;
      endcase
      return s;
   endfunction

   assign tick       = (cnt == CMAX);
   assign frame_edge = tick && (idx == 2'd3);

   // Prescaler: one tick every SCAN_DIV cycles
   always_ff @(posedge CLK) begin
      if (!RES) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Digit slot index advances once per tick
   always_ff @(posedge CLK) begin
      if (!RES) begin
         idx <= 2'd0;
      end else if (tick) begin
         idx <= idx + 2'd1;
      end
   end

   // Pending capture; display only changes on a frame boundary
   always_ff @(posedge CLK) begin
      if (!RES) begin
         pend       <= 16'h0000;
         pend_valid <= 1'b0;
         disp       <= 16'h0000;
      end else begin
         if (bus.LOAD) begin
            pend <= bus.DIGITS;
         end
         if (frame_edge) begin
            pend_valid <= 1'b0;
            if (bus.LOAD) begin
               disp <= bus.DIGITS;
            end else if (pend_valid) begin
               disp <= pend;
            end
         end else if (bus.LOAD) begin
            pend_valid <= 1'b1;
         end
      end
   end

   // Select the current digit and its blanking status
   always_comb begin
      dig = disp[3:0];
      unique case (idx)
         2'd0: dig = disp[3:0];
         2'd1: dig = disp[7:4];
         2'd2: dig = disp[11:8];
         2'd3: dig = disp[15:12];
      endcase
      lz[3] = (disp[15:12] == 4'd0);
      lz[2] = lz[3] && (disp[11:8] == 4'd0);
      lz[1] = lz[2] && (disp[7:4] == 4'd0);
      lz[0] = 1'b0;
      if (BLANK_LZ && lz[idx]) begin
         seg_nxt = 7'b0000000;
      end else begin
         seg_nxt = seg7(dig);
      end
      bad = (disp[3:0]   > 4'd9) ||
            (disp[7:4]   > 4'd9) ||
            (disp[11:8]  > 4'd9) ||
            (disp[15:12] > 4'd9);
   end

   // Registered display drive, frame pulse and sticky error
   always_ff @(posedge CLK) begin
      if (!RES) begin
         bus.SEG   <= 7'b0000000;
         bus.AN    <= 4'b1111;
         bus.ERR   <= 1'b0;
         bus.FRAME <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         bus.SEG   <= seg_nxt;
         bus.AN    <= ~(4'b0001 << idx);
         bus.ERR   <= bus.ERR | bad;
         wrap_q    <= frame_edge;
         bus.FRAME <= wrap_q;
      end
   end

endmodule
